// File: rtl/life_pkg.sv
// Shared types and constants for the life grid controller.
package life_pkg;

  localparam int unsigned LIFE_ROWS = 8;
  localparam int unsigned LIFE_COLS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STEP,
    CHECK,
    HALT
  } life_state_e;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_PAUSE = 2'd2;
  localparam logic [1:0] OP_STEP  = 2'd3;

endpackage

// File: rtl/life_rate_timer.sv
// Idle-cycle timer for free-running mode; expire is high while count equals rate.
module life_rate_timer #(
  parameter int unsigned RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  output logic              expire
);

  logic [RATE_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == rate);

endmodule

// File: rtl/life_sequencer.sv
// Life matrix controller: row loading, run/step sequencing, generation count, halt detection.
// Define LIFE_STABLE_DETECT_EN to also halt when a step leaves the grid unchanged.
module life_sequencer
  import life_pkg::*;
#(
  parameter int unsigned ROWS   = LIFE_ROWS,
  parameter int unsigned COLS   = LIFE_COLS,
  parameter int unsigned GEN_W  = 16,
  parameter int unsigned RATE_W = 8
) (
  input  logic                     clk,
  input  logic                     _rst,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  output logic                     cmd_ready,
  input  logic                     row_valid,
  input  logic [COLS-1:0]          row_data,
  output logic                     row_ready,
  input  logic [RATE_W-1:0]        rate,
  input  logic [ROWS*COLS-1:0]     grid_in,
  output logic                     step_en,
  output logic                     load_en,
  output logic [$clog2(ROWS)-1:0] load_row,
  output logic [COLS-1:0]          load_data,
  output logic [GEN_W-1:0]         gen_count,
  output logic                     busy,
  output logic                     extinct,
  output logic                     stable
);

  localparam int unsigned IDX_W = $clog2(ROWS);

  life_state_e      state_q, state_d;
  logic             from_run_q, from_run_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             load_en_q, load_en_d;
  logic [IDX_W-1:0] load_row_q, load_row_d;
  logic [COLS-1:0]  load_data_q, load_data_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             extinct_q, extinct_d;
  logic             stable_q, stable_d;
  logic             cmd_ready_q, row_ready_q, busy_q, step_en_q;

  logic cmd_fire, row_fire;
  logic tmr_clear, tmr_enable, tmr_expire;
  logic grid_empty, grid_same;

  assign cmd_fire   = cmd_valid & cmd_ready_q;
  assign row_fire   = row_valid & row_ready_q;
  assign grid_empty = (grid_in == '0);

  life_rate_timer #(.RATE_W(RATE_W)) u_timer (
    .clk    (clk),
    .rst    (_rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .rate   (rate),
    .expire (tmr_expire)
  );

`ifdef LIFE_STABLE_DETECT_EN
  logic [ROWS*COLS-1:0] snap_q, snap_d;

  // STEP sees the pre-step grid; CHECK compares it with the post-step grid.
  always_comb begin
    snap_d = snap_q;
    if (state_q == STEP) snap_d = grid_in;
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) snap_q <= '0;
    else      snap_q <= snap_d;
  end

  assign grid_same = (grid_in == snap_q);
`else
  assign grid_same = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    from_run_d  = from_run_q;
    idx_d       = idx_q;
    load_en_d   = 1'b0;
    load_row_d  = load_row_q;
    load_data_d = load_data_q;
    gen_d       = gen_q;
    extinct_d   = extinct_q;
    stable_d    = stable_q;
    tmr_clear   = 1'b1;
    tmr_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_op == OP_LOAD) begin
            state_d = LOAD;
            idx_d   = '0;
          end else if (cmd_op == OP_RUN) begin
            state_d = RUN;
          end else if (cmd_op == OP_STEP) begin
            state_d    = STEP;
            from_run_d = 1'b0;
          end
        end
      end
      RUN: begin
        tmr_clear  = 1'b0;
        tmr_enable = 1'b1;
        if (cmd_fire && cmd_op == OP_PAUSE) begin
          state_d = IDLE;
        end else if (cmd_fire && cmd_op == OP_LOAD) begin
          state_d = LOAD;
          idx_d   = '0;
        end else if (tmr_expire) begin
          state_d    = STEP;
          from_run_d = 1'b1;
        end
      end
      LOAD: begin
        if (row_fire) begin
          load_en_d   = 1'b1;
          load_row_d  = idx_q;
          load_data_d = row_data;
          idx_d       = idx_q + 1'b1;
          if (idx_q == IDX_W'(ROWS - 1)) begin
            state_d   = IDLE;
            gen_d     = '0;
            extinct_d = 1'b0;
            stable_d  = 1'b0;
          end
        end
      end
      STEP: begin
        gen_d   = gen_q + 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (grid_empty) begin
          state_d   = HALT;
          extinct_d = 1'b1;
        end else if (grid_same) begin
          state_d  = HALT;
          stable_d = 1'b1;
        end else if (from_run_q) begin
          // CHECK counts as the first idle cycle, so rate 0 goes straight back to STEP
          tmr_clear  = 1'b0;
          tmr_enable = 1'b1;
          state_d    = tmr_expire ? STEP : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        if (cmd_fire && cmd_op == OP_LOAD) begin
          state_d   = LOAD;
          idx_d     = '0;
          extinct_d = 1'b0;
          stable_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge _rst) begin
    if (_rst) begin
      state_q     <= IDLE;
      from_run_q  <= 1'b0;
      idx_q       <= '0;
      load_en_q   <= 1'b0;
      load_row_q  <= '0;
      load_data_q <= '0;
      gen_q       <= '0;
      extinct_q   <= 1'b0;
      stable_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      row_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      step_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      from_run_q  <= from_run_d;
      idx_q       <= idx_d;
      load_en_q   <= load_en_d;
      load_row_q  <= load_row_d;
      load_data_q <= load_data_d;
      gen_q       <= gen_d;
      extinct_q   <= extinct_d;
      stable_q    <= stable_d;
      cmd_ready_q <= (state_d == IDLE) || (state_d == RUN) || (state_d == HALT);
      row_ready_q <= (state_d == LOAD);
      busy_q      <= (state_d == LOAD) || (state_d == STEP) || (state_d == CHECK);
      step_en_q   <= (state_d == STEP);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign row_ready = row_ready_q;
  assign busy      = busy_q;
  assign step_en   = step_en_q;
  assign load_en   = load_en_q;
  assign load_row  = load_row_q;
  assign load_data = load_data_q;
  assign gen_count = gen_q;
  assign extinct   = extinct_q;
  assign stable    = stable_q;

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
- Controller for the 8x8 life cell matrix.
- Loads an initial pattern one row at a time through the matrix's load path.
- Issues generation-advance pulses, either free-running at a programmable rate or as single steps, and counts generations.
- Halts automatically when the grid dies out; optionally also halts when the grid stops changing.
- Sits between the host/command logic and the matrix.

Parameters:
ROWS, 8, grid rows
COLS, 8, grid columns (row word width)
GEN_W, 16, generation counter width
RATE_W, 8, width of rate (idle cycles between steps)

Ports:
clk  in  1  clock
_rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_op  in  2  0=LOAD 1=RUN 2=PAUSE 3=STEP
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
row_valid  in  1  load row offered
row_data  in  COLS  row pattern, bit c = column c
row_ready  out  1  row accepted when row_valid&row_ready
rate  in  RATE_W  RUN idle cycles per generation, sampled every cycle
grid_in  in  ROWS*COLS  current matrix state, bit r*COLS+c
step_en  out  1  one-cycle generation-advance pulse to matrix
load_en  out  1  write row to matrix
load_row  out  $clog2(ROWS)  target row index
load_data  out  COLS  row value
gen_count  out  GEN_W  generations since last completed LOAD
busy  out  1  state is LOAD, STEP or CHECK
extinct  out  1  halted because grid empty
stable  out  1  halted because grid unchanged (macro only)

Behaviour:
- States: IDLE, LOAD, RUN, STEP, CHECK, HALT. All state is reset on _rst.
- Reset values: state=IDLE, all outputs 0, tick and row counters 0.
- Reset mid-LOAD leaves rows already written in the matrix untouched.
- cmd_ready=1 in IDLE, RUN and HALT; 0 otherwise.
- Commands accepted in IDLE:
  - LOAD -> LOAD, row index 0.
  - RUN -> RUN, tick counter 0.
  - STEP -> STEP (single-step mode).
  - PAUSE: no-op.
- Commands accepted in RUN:
  - PAUSE -> IDLE next cycle.
  - LOAD -> LOAD (aborts run).
  - RUN and STEP: no-op.
- Commands accepted in HALT:
  - LOAD -> LOAD; clears extinct and stable.
  - All others are consumed and ignored.
- LOAD state:
  - row_ready=1.
  - Each accepted row drives load_en=1, load_row=idx and load_data=row_data on the following cycle (registered, one-cycle latency); idx then increments.
  - After row ROWS-1 is accepted: gen_count cleared to 0, extinct and stable cleared, -> IDLE.
  - row_ready=0 in every other state; rows offered outside LOAD are not consumed.
- RUN:
  - Tick counter increments each cycle.
  - When tick==rate: -> STEP, tick cleared.
  - rate=0 means no idle cycles, giving a period of rate+2 cycles per generation.
  - A lower rate than the current tick takes effect at the next STEP.
- STEP:
  - step_en=1 for exactly one cycle.
  - gen_count increments, wrapping at 2^GEN_W.
  - -> CHECK.
- CHECK:
  - Samples grid_in, which is the post-step value.
  - grid_in==0 -> HALT with extinct=1 (has priority over stable).
  - Otherwise -> RUN if entered from RUN, else IDLE.
- HALT: step_en stays 0; extinct and stable hold until the next LOAD completes or reset.
- The matrix steps only on step_en; a free-running matrix is not permitted.

Optional Feature:
- Macro: LIFE_STABLE_DETECT_EN.
- Defined:
  - In STEP, snapshot grid_in (pre-step) into a ROWS*COLS register.
  - In CHECK, if not extinct and grid_in==snapshot -> HALT with stable=1.
  - Oscillators are not detected.
- Undefined: no snapshot register; stable is tied 0; CHECK tests extinction only.

Decomposition:
- Package life_pkg holds:
  - state enum: IDLE, LOAD, RUN, STEP, CHECK, HALT.
  - opcode constants: OP_LOAD, OP_RUN, OP_PAUSE, OP_STEP.
  - default ROWS/COLS.
- One sub-module, life_rate_timer:
  - Inputs: clear, enable, rate.
  - Outputs: expire pulse when count==rate.
  - Used by the RUN state.

Test Plan:
- LOAD, then 8 rows with row 2 = 8'b0000_0111 (blinker); the bench holds row_valid high -> load_en asserted 8 consecutive cycles, load_row 0..7, gen_count=0, back in IDLE, cmd_ready=1.
- Blinker loaded, STEP x3 -> exactly 3 step_en pulses, gen_count=3, extinct=0, state IDLE after each.
- Blinker loaded, rate=3, RUN, PAUSE after 20 cycles -> step_en period 5 cycles, gen_count=4, state IDLE, no step_en after PAUSE is accepted.
- Single live cell loaded, RUN with rate=0 -> one step_en, CHECK sees grid_in=0, HALT, extinct=1; a later RUN is ignored; LOAD clears extinct.
- With LIFE_STABLE_DETECT_EN, 2x2 block loaded, RUN -> one step, HALT, stable=1, gen_count=1. Without the macro -> runs indefinitely, stable=0.
- _rst asserted after 4 of 8 rows accepted -> immediately IDLE, load_en=0, row_ready=0, gen_count=0, busy=0.
